// File: rtl/dg0045_rom_fetch_ctrl.sv
// Instruction fetch sequencer for the DG0045 core: drives PC_MUX, assembles the
// 10-bit PC from PC_HL, runs one req/ack read per 8-clock cycle, NOP on timeout.
module dg0045_rom_fetch_ctrl #(
  parameter int unsigned TIMEOUT  = 3,
  parameter logic [7:0]  NOP_BYTE = 8'h00,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             CLK_main,
  input  logic             RESET,
  output logic             pc_mux,
  input  logic [4:0]       pc_hl,
  output logic             mem_req,
  output logic [9:0]       mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  output logic [7:0]       rom_data,
  output logic             fetch_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    TOUT,
    DONE
  } state_e;

  localparam logic [1:0] TimerLast = 2'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       timer_q, timer_d;
  logic [2:0]       ph_q;
  logic             pc_mux_q, pc_mux_d;
  logic [4:0]       addr_lo_q;
  logic [9:0]       mem_addr_q;
  logic [7:0]       rom_data_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic ph_last;
  logic ack_take;
  logic tout_hit;

  assign ph_last  = (ph_q == 3'd7);
  assign ack_take = (state_q == REQ) && mem_ack;
  assign tout_hit = (state_q == REQ) && !mem_ack && (timer_q == TimerLast);
  assign pc_mux_d = (ph_q == 3'd5) || (ph_q == 3'd6);

  always_ff @(posedge CLK_main or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // DONE may still be waiting for ph 3 when the next ph 7 edge arrives after a
  // late-phase completion, so it launches the next request directly as well.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (ph_last) begin
          state_d = REQ;
          timer_d = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (timer_q == TimerLast) begin
          state_d = TOUT;
        end else begin
          timer_d = timer_q + 2'd1;
        end
      end
      TOUT: state_d = DONE;
      DONE: begin
        if (ph_last) begin
          state_d = REQ;
          timer_d = '0;
        end else if (ph_q == 3'd3) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == REQ);
    busy      = (state_q == REQ);
    fetch_err = (state_q == TOUT);
  end

  always_ff @(posedge CLK_main or negedge RESET) begin
    if (!RESET) begin
      ph_q       <= '0;
      pc_mux_q   <= 1'b0;
      addr_lo_q  <= '0;
      mem_addr_q <= '0;
      rom_data_q <= NOP_BYTE;
      err_cnt_q  <= '0;
    end else begin
      ph_q     <= ph_q + 3'd1;
      pc_mux_q <= pc_mux_d;
      if (ph_q == 3'd5) begin
        addr_lo_q <= pc_hl;
      end
      if (ph_last) begin
        mem_addr_q <= {pc_hl, addr_lo_q};
      end
      // NOP and the error count land as TOUT is entered, so both are visible
      // alongside the fetch_err pulse.
      if (ack_take) begin
        rom_data_q <= mem_data;
      end else if (tout_hit) begin
        rom_data_q <= NOP_BYTE;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign pc_mux   = pc_mux_q;
  assign mem_addr = mem_addr_q;
  assign rom_data = rom_data_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dg0045_rom_fetch_ctrl.sv
// Bench for dg0045_rom_fetch_ctrl: per-frame fetch model checked every cycle,
// plus literal expectations on recorded per-frame observations.
module tb_dg0045_rom_fetch_ctrl;

  localparam int         TIMEOUT = 3;
  localparam logic [7:0] NOP     = 8'h00;
  localparam int         NF      = 280;

  logic       CLK_main = 1'b0;
  logic       RESET    = 1'b0;
  logic       pc_mux;
  logic [4:0] pc_hl    = '0;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic       mem_ack  = 1'b0;
  logic [7:0] mem_data = '0;
  logic [7:0] rom_data;
  logic       fetch_err;
  logic [7:0] err_cnt;
  logic       busy;

  always #5 CLK_main = ~CLK_main;

  dg0045_rom_fetch_ctrl #(
    .TIMEOUT (TIMEOUT),
    .NOP_BYTE(NOP),
    .ERR_W   (8)
  ) dut (
    .CLK_main (CLK_main),
    .RESET    (RESET),
    .pc_mux   (pc_mux),
    .pc_hl    (pc_hl),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .rom_data (rom_data),
    .fetch_err(fetch_err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  // Per frame: PC presented during the frame, ack phase (-1 none), spurious ack phase, data.
  logic [9:0] cfg_pc  [NF];
  int         cfg_ack [NF];
  int         cfg_spur[NF];
  logic [7:0] cfg_dat [NF];

  int         rec_req  [NF];
  int         rec_err  [NF];
  logic [7:0] rec_mux  [NF];
  logic [7:0] rec_rom4 [NF];
  logic [7:0] rec_cnt4 [NF];
  logic [9:0] rec_addr4[NF];

  int         tb_ph, tb_frame, rst_frame;
  bit         chk_en = 1'b0;
  logic [7:0] prev_rom, prev_cnt;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cur();
    logic [9:0] pcv;
    int f, p;
    f   = tb_frame;
    p   = tb_ph;
    pcv = cfg_pc[f];
    if (p == 4 || p == 5)  pc_hl = pcv[4:0];
    else if (p >= 6)       pc_hl = pcv[9:5];
    else                   pc_hl = 5'($urandom);
    mem_ack  = (p == cfg_ack[f]) || (p == cfg_spur[f]);
    mem_data = mem_ack ? cfg_dat[f] : 8'($urandom);
  endtask

  task automatic step();
    @(posedge CLK_main);
    #1;
    tb_ph = (tb_ph + 1) % 8;
    if (tb_ph == 0) tb_frame++;
    drive_cur();
  endtask

  // Fetch model: frame f (after the first post-reset frame) reads cfg_pc[f-1].
  int         m_f, m_p, m_a, m_last;
  bit         m_fetch, m_acked, m_tout;
  logic [7:0] e_rom, e_cnt, m_mux;
  logic [9:0] e_addr;

  always @(negedge CLK_main) begin
    if (chk_en) begin
      m_f     = tb_frame;
      m_p     = tb_ph;
      m_fetch = (m_f > rst_frame);
      m_a     = cfg_ack[m_f];
      m_acked = m_fetch && (m_a >= 0) && (m_a < TIMEOUT);
      m_tout  = m_fetch && !m_acked;
      m_last  = m_acked ? m_a : TIMEOUT - 1;
      e_rom   = prev_rom;
      e_cnt   = prev_cnt;
      if (m_acked && m_p > m_a) e_rom = cfg_dat[m_f];
      if (m_tout && m_p >= TIMEOUT) begin
        e_rom = NOP;
        e_cnt = (prev_cnt == 8'hFF) ? 8'hFF : prev_cnt + 8'd1;
      end
      e_addr = m_fetch ? cfg_pc[m_f-1] : 10'h000;

      check($sformatf("pc_mux f%0d ph%0d", m_f, m_p), 32'(pc_mux), 32'(m_p >= 6));
      check($sformatf("mem_req f%0d ph%0d", m_f, m_p), 32'(mem_req), 32'(m_fetch && m_p <= m_last));
      check($sformatf("busy f%0d ph%0d", m_f, m_p), 32'(busy), 32'(m_fetch && m_p <= m_last));
      check($sformatf("fetch_err f%0d ph%0d", m_f, m_p), 32'(fetch_err), 32'(m_tout && m_p == TIMEOUT));
      check($sformatf("rom_data f%0d ph%0d", m_f, m_p), 32'(rom_data), 32'(e_rom));
      check($sformatf("err_cnt f%0d ph%0d", m_f, m_p), 32'(err_cnt), 32'(e_cnt));
      check($sformatf("mem_addr f%0d ph%0d", m_f, m_p), 32'(mem_addr), 32'(e_addr));

      if (m_p == 0) begin
        rec_req[m_f] = 0;
        rec_err[m_f] = 0;
        rec_mux[m_f] = '0;
      end
      rec_req[m_f] += int'(mem_req);
      rec_err[m_f] += int'(fetch_err);
      m_mux        = rec_mux[m_f];
      m_mux[m_p]   = pc_mux;
      rec_mux[m_f] = m_mux;
      if (m_p == 4) begin
        rec_rom4[m_f]  = rom_data;
        rec_cnt4[m_f]  = err_cnt;
        rec_addr4[m_f] = mem_addr;
      end
      if (m_p == 7) begin
        prev_rom = e_rom;
        prev_cnt = e_cnt;
      end
    end
  end

  initial begin
    for (int i = 0; i < NF; i++) begin
      cfg_pc[i]   = 10'($urandom);
      cfg_ack[i]  = -1;
      cfg_spur[i] = -1;
      cfg_dat[i]  = 8'($urandom);
      rec_req[i]  = -1;
      rec_err[i]  = -1;
      rec_mux[i]  = 'x;
      rec_rom4[i] = 'x;
      rec_cnt4[i] = 'x;
      rec_addr4[i] = 'x;
    end
    cfg_pc[0] = 10'h2A5;
    cfg_ack[1] = 0; cfg_dat[1] = 8'hC3; cfg_pc[1] = 10'h13C;
    cfg_ack[2] = 5; cfg_dat[2] = 8'hAA; cfg_pc[2] = 10'h3FF;
    cfg_ack[3] = 2; cfg_dat[3] = 8'h5E; cfg_pc[3] = 10'h001;
    cfg_ack[4] = 1; cfg_dat[4] = 8'h77;
    for (int i = 5; i <= 264; i++) cfg_spur[i] = 6;
    cfg_ack[265] = 0; cfg_dat[265] = 8'h9A;
    cfg_pc[267]  = 10'h155;
    cfg_ack[268] = 1; cfg_dat[268] = 8'h3C;

    repeat (3) @(posedge CLK_main);
    #1;
    check("reset pc_mux", 32'(pc_mux), 32'h0);
    check("reset mem_req", 32'(mem_req), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h000);
    check("reset rom_data", 32'(rom_data), 32'h00);
    check("reset fetch_err", 32'(fetch_err), 32'h0);
    check("reset err_cnt", 32'(err_cnt), 32'h00);

    RESET     = 1'b1;
    tb_ph     = 0;
    tb_frame  = 0;
    rst_frame = 0;
    prev_rom  = NOP;
    prev_cnt  = 8'h00;
    chk_en    = 1'b1;
    drive_cur();
    while (!(tb_frame == 266 && tb_ph == 1)) step();

    // Reset while the request from frame 266 is outstanding.
    RESET  = 1'b0;
    chk_en = 1'b0;
    #1;
    check("midreset mem_req", 32'(mem_req), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset rom_data", 32'(rom_data), 32'h00);
    check("midreset err_cnt", 32'(err_cnt), 32'h00);
    check("midreset fetch_err", 32'(fetch_err), 32'h0);
    @(posedge CLK_main);
    #1;
    check("inreset mem_req", 32'(mem_req), 32'h0);
    check("inreset mem_addr", 32'(mem_addr), 32'h000);

    RESET     = 1'b1;
    tb_ph     = 0;
    tb_frame  = 267;
    rst_frame = 267;
    prev_rom  = NOP;
    prev_cnt  = 8'h00;
    chk_en    = 1'b1;
    drive_cur();
    while (!(tb_frame == 269 && tb_ph == 5)) step();
    chk_en = 1'b0;

    check("f0 pc_mux pattern", 32'(rec_mux[0]), 32'hC0);
    check("f1 pc_mux pattern", 32'(rec_mux[1]), 32'hC0);
    check("f0 no request", 32'(rec_req[0]), 32'd0);
    check("f1 req clocks", 32'(rec_req[1]), 32'd1);
    check("f1 addr", 32'(rec_addr4[1]), 32'h2A5);
    check("f1 rom", 32'(rec_rom4[1]), 32'hC3);
    check("f1 err pulses", 32'(rec_err[1]), 32'd0);
    check("f2 req clocks", 32'(rec_req[2]), 32'd3);
    check("f2 err pulses", 32'(rec_err[2]), 32'd1);
    check("f2 rom", 32'(rec_rom4[2]), 32'h00);
    check("f2 err_cnt", 32'(rec_cnt4[2]), 32'h01);
    check("f2 addr", 32'(rec_addr4[2]), 32'h13C);
    check("f3 req clocks", 32'(rec_req[3]), 32'd3);
    check("f3 err pulses", 32'(rec_err[3]), 32'd0);
    check("f3 rom", 32'(rec_rom4[3]), 32'h5E);
    check("f3 err_cnt", 32'(rec_cnt4[3]), 32'h01);
    check("f3 addr", 32'(rec_addr4[3]), 32'h3FF);
    check("f4 rom", 32'(rec_rom4[4]), 32'h77);
    check("f4 addr", 32'(rec_addr4[4]), 32'h001);
    check("f257 err_cnt", 32'(rec_cnt4[257]), 32'hFE);
    check("f258 err_cnt", 32'(rec_cnt4[258]), 32'hFF);
    check("f264 err_cnt", 32'(rec_cnt4[264]), 32'hFF);
    check("f264 err pulses", 32'(rec_err[264]), 32'd1);
    check("f265 rom", 32'(rec_rom4[265]), 32'h9A);
    check("f267 no request", 32'(rec_req[267]), 32'd0);
    check("f267 pc_mux pattern", 32'(rec_mux[267]), 32'hC0);
    check("f267 addr", 32'(rec_addr4[267]), 32'h000);
    check("f268 req clocks", 32'(rec_req[268]), 32'd2);
    check("f268 rom", 32'(rec_rom4[268]), 32'h3C);
    check("f268 addr", 32'(rec_addr4[268]), 32'h155);
    check("f268 err_cnt", 32'(rec_cnt4[268]), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
